eaglesong_coef_sequencer: RTL and testbench
===========================================

EAGLESONG_COEF_SEQUENCER -- requirements
Module: eaglesong_coef_sequencer

Interface
REQ-001 SHALL have parameter LANES, 4, words per output beat; legal {1,2,4,8,16}; any other value is an elaboration error.
REQ-002 SHALL have parameter COEF_W, 5, bits per coefficient.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  request a coefficient stream.
REQ-006 SHALL have port rounds  in  6  number of rounds to stream, sampled at start acceptance.
REQ-007 SHALL have port abort  in  1  synchronous stream cancel.
REQ-008 SHALL have port out_ready  in  1  downstream accepts beat.
REQ-009 SHALL have port out_valid  out  1  beat present.
REQ-010 SHALL have port out_coef  out  LANES*3*COEF_W  coefficient triples; lane l at bits [l*3*COEF_W +: 3*COEF_W], coef0 at LSB of each triple.
REQ-011 SHALL have port out_word  out  4  word index of lane 0.
REQ-012 SHALL have port out_round  out  6  current round index, 0-based.
REQ-013 SHALL have port out_round_last  out  1  final beat of a round.
REQ-014 SHALL have port out_last  out  1  final beat of final round.
REQ-015 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-016 SHALL implement states IDLE and STREAM.
REQ-017 IDLE->STREAM SHALL occur when start=1 and rounds!=0; start with rounds=0, or start in STREAM, SHALL be ignored.
REQ-018 First beat SHALL be valid the cycle after start acceptance (latency 1); all outputs registered.
REQ-019 Each round SHALL be 16/LANES beats; beat k carries words k*LANES .. k*LANES+LANES-1.
REQ-020 Word w triple SHALL be (0,a,b) with (a,b) for w=0..15: (2,4),(13,22),(4,19),(3,14),(27,31),(3,8),(17,26),(3,12),(18,22),(12,18),(4,7),(4,31),(12,27),(7,17),(7,8),(1,13).
REQ-021 A beat SHALL transfer only when out_valid=1 and out_ready=1; otherwise all out_* SHALL hold stable.
REQ-022 Word index SHALL wrap 16->0 and out_round increment on the transfer of an out_round_last beat.
REQ-023 On transfer of the out_last beat, state SHALL return to IDLE and out_valid SHALL be 0 next cycle unless start is accepted back-to-back (start=1 that same cycle is ignored; earliest restart is the following cycle).
REQ-024 abort=1 SHALL force IDLE with out_valid=0 next cycle, overriding any transfer; abort in IDLE SHALL have no effect.
REQ-025 rounds=63 SHALL stream 63 rounds without counter overflow.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, out_valid=0, busy=0, out_coef=0, out_word=0, out_round=0, out_round_last=0, out_last=0, regardless of clk.
REQ-027 Reset mid-stream SHALL discard the stream; first post-reset start SHALL begin at word 0, round 0.

Configuration
REQ-028 With EAGLESONG_COEF_PARITY_EN defined, SHALL add port out_parity  out  LANES, bit l = even parity (XOR) over lane l's 3*COEF_W bits, registered and held with the beat.
REQ-029 Without EAGLESONG_COEF_PARITY_EN, out_parity and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package eaglesong_pkg SHALL hold NUM_WORDS=16, COEFS_PER_WORD=3, the 16x(a,b) coefficient table, and the state enum.
REQ-031 Combinational sub-module eaglesong_coef_triple_lookup SHALL map 4-bit word index to one 3*COEF_W triple; instantiated LANES times.

Verification
REQ-032 LANES=1, rounds=1, out_ready=1: 16 beats on consecutive cycles; beat 4 out_coef={31,27,0}; out_last on beat 15; busy=0 the cycle after.
REQ-033 LANES=4, rounds=2: 8 beats; beat 0 lane1={22,13,0}; out_round_last on beats 3 and 7; out_round 0 for beats 0-3, 1 for 4-7.
REQ-034 LANES=1, out_ready=0 for 3 cycles at beat 2: out_word=2, out_coef={19,4,0} held 4 cycles, no skipped word.
REQ-035 start with rounds=0 -> busy stays 0; start during STREAM -> stream unaffected; abort at beat 5 -> out_valid=0 next cycle, later start restarts at word 0.
REQ-036 rst_n low mid-cycle at beat 7 -> outputs zero without clk edge; with EAGLESONG_COEF_PARITY_EN, LANES=1 word 4 -> out_parity=1.

Source files
------------

// File: rtl/eaglesong_pkg.sv
// Shared definitions for the Eaglesong coefficient sequencer: word geometry,
// the per-word (a,b) rotation-coefficient table and the sequencer state enum.
package eaglesong_pkg;

  localparam int NUM_WORDS      = 16;
  localparam int COEFS_PER_WORD = 3;
  localparam int TABLE_COEF_W   = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } seq_state_e;

  // Second and third coefficient of each word; the first is always zero.
  localparam logic [TABLE_COEF_W-1:0] COEF_A_TABLE [NUM_WORDS] = '{
    5'd2,  5'd13, 5'd4,  5'd3,  5'd27, 5'd3,  5'd17, 5'd3,
    5'd18, 5'd12, 5'd4,  5'd4,  5'd12, 5'd7,  5'd7,  5'd1
  };

  localparam logic [TABLE_COEF_W-1:0] COEF_B_TABLE [NUM_WORDS] = '{
    5'd4,  5'd22, 5'd19, 5'd14, 5'd31, 5'd8,  5'd26, 5'd12,
    5'd22, 5'd18, 5'd7,  5'd31, 5'd27, 5'd17, 5'd8,  5'd13
  };

endpackage

// File: rtl/eaglesong_coef_triple_lookup.sv
// Combinational map from a 4-bit word index to its coefficient triple
// {b, a, 0}, coef0 in the least significant COEF_W bits.
module eaglesong_coef_triple_lookup
  import eaglesong_pkg::*;
#(
  parameter int COEF_W = 5
) (
  input  logic [3:0]                         word,
  output logic [COEFS_PER_WORD*COEF_W-1:0]   triple
);

  assign triple = {COEF_W'(COEF_B_TABLE[word]),
                   COEF_W'(COEF_A_TABLE[word]),
                   {COEF_W{1'b0}}};

endmodule

// File: rtl/eaglesong_coef_sequencer.sv
// Streams the Eaglesong coefficient table, LANES words per beat, for a
// requested number of rounds with valid/ready flow control.
// Optional build macro: EAGLESONG_COEF_PARITY_EN adds per-lane even parity
// on out_parity.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no stream; out_valid=0; waiting for start with rounds!=0
// ST_STREAM | beat held on out_* until accepted; abort returns to idle
module eaglesong_coef_sequencer
  import eaglesong_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int COEF_W = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [5:0]                              rounds,
  input  logic                                    abort,
  input  logic                                    out_ready,
  output logic                                    out_valid,
  output logic [LANES*COEFS_PER_WORD*COEF_W-1:0]  out_coef,
  output logic [3:0]                              out_word,
  output logic [5:0]                              out_round,
  output logic                                    out_round_last,
  output logic                                    out_last,
  output logic                                    busy
`ifdef EAGLESONG_COEF_PARITY_EN
  ,
  output logic [LANES-1:0]                        out_parity
`endif
);

  localparam int TRIPLE_W        = COEFS_PER_WORD * COEF_W;
  localparam int BEATS_PER_ROUND = NUM_WORDS / LANES;
  localparam logic [3:0] LANE_STEP = 4'(LANES);
  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - LANES);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("eaglesong_coef_sequencer: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  seq_state_e                    state;
  logic [5:0]                    rounds_q;
  logic [3:0]                    next_word;
  logic [5:0]                    next_round;
  logic [3:0]                    base_word;
  logic                          load_first;
  logic                          stop_strm;
  logic                          advance;
  logic [LANES*TRIPLE_W-1:0]     next_coef;

  // Next-beat addressing and the three events that move the output register.
  always_comb begin
    next_word  = out_word + LANE_STEP;
    next_round = out_round_last ? out_round + 6'd1 : out_round;
    base_word  = (state == ST_IDLE) ? 4'd0 : next_word;
    load_first = (state == ST_IDLE) && start && (rounds != 6'd0);
    stop_strm  = (state == ST_STREAM) && (abort || (out_ready && out_last));
    advance    = (state == ST_STREAM) && !abort && out_ready && !out_last;
  end

  // One lookup per lane, addressed for the beat about to be loaded.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      eaglesong_coef_triple_lookup #(
        .COEF_W (COEF_W)
      ) u_lookup (
        .word   (base_word + 4'(l)),
        .triple (next_coef[l*TRIPLE_W +: TRIPLE_W])
      );
    end
  endgenerate

  // Sequencer state and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rounds_q       <= '0;
      out_valid      <= 1'b0;
      out_coef       <= '0;
      out_word       <= '0;
      out_round      <= '0;
      out_round_last <= 1'b0;
      out_last       <= 1'b0;
    end else if (load_first) begin
      state          <= ST_STREAM;
      rounds_q       <= rounds;
      out_valid      <= 1'b1;
      out_coef       <= next_coef;
      out_word       <= 4'd0;
      out_round      <= 6'd0;
      out_round_last <= (BEATS_PER_ROUND == 1);
      out_last       <= (BEATS_PER_ROUND == 1) && (rounds == 6'd1);
    end else if (stop_strm) begin
      state          <= ST_IDLE;
      out_valid      <= 1'b0;
      out_coef       <= '0;
      out_word       <= '0;
      out_round      <= '0;
      out_round_last <= 1'b0;
      out_last       <= 1'b0;
    end else if (advance) begin
      out_coef       <= next_coef;
      out_word       <= next_word;
      out_round      <= next_round;
      out_round_last <= (next_word == LAST_WORD);
      // rounds_q >= 1 whenever streaming, so rounds_q-1 never wraps.
      out_last       <= (next_word == LAST_WORD) && (next_round == rounds_q - 6'd1);
    end
  end

  assign busy = (state == ST_STREAM);

`ifdef EAGLESONG_COEF_PARITY_EN
  logic [LANES-1:0] next_parity;

  // Even parity of each lane triple, computed ahead of the load.
  always_comb begin
    next_parity = '0;
    for (int l = 0; l < LANES; l++) begin
      next_parity[l] = ^next_coef[l*TRIPLE_W +: TRIPLE_W];
    end
  end

  // Parity register tracks out_coef exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= '0;
    end else if (load_first || advance) begin
      out_parity <= next_parity;
    end else if (stop_strm) begin
      out_parity <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_eaglesong_coef_sequencer.sv
// Self-checking bench: two sequencers (LANES=4 and LANES=1) share stimulus and
// are compared every cycle against a beat-count model of the stream.
module tb_eaglesong_coef_sequencer;

  localparam int CW = 5;
  localparam int TW = 3 * CW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] rounds = 6'd0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;

  logic             o_valid [2];
  logic             o_busy  [2];
  logic             o_rlast [2];
  logic             o_last  [2];
  logic [3:0]       o_word  [2];
  logic [5:0]       o_round [2];
  logic [4*TW-1:0]  cf4;
  logic [TW-1:0]    cf1;
  logic [4*TW-1:0]  o_coef  [2];

  assign o_coef[0] = cf4;
  assign o_coef[1] = {{(3*TW){1'b0}}, cf1};

`ifdef EAGLESONG_COEF_PARITY_EN
  logic [3:0] par4;
  logic [0:0] par1;
  logic [3:0] o_par [2];
  assign o_par[0] = par4;
  assign o_par[1] = {3'b000, par1};
`endif

  always #5 clk = ~clk;

  eaglesong_coef_sequencer #(.LANES(4), .COEF_W(CW)) u_dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rounds         (rounds),
    .abort          (abort),
    .out_ready      (out_ready),
    .out_valid      (o_valid[0]),
    .out_coef       (cf4),
    .out_word       (o_word[0]),
    .out_round      (o_round[0]),
    .out_round_last (o_rlast[0]),
    .out_last       (o_last[0]),
    .busy           (o_busy[0])
`ifdef EAGLESONG_COEF_PARITY_EN
    ,
    .out_parity     (par4)
`endif
  );

  eaglesong_coef_sequencer #(.LANES(1), .COEF_W(CW)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rounds         (rounds),
    .abort          (abort),
    .out_ready      (out_ready),
    .out_valid      (o_valid[1]),
    .out_coef       (cf1),
    .out_word       (o_word[1]),
    .out_round      (o_round[1]),
    .out_round_last (o_rlast[1]),
    .out_last       (o_last[1]),
    .busy           (o_busy[1])
`ifdef EAGLESONG_COEF_PARITY_EN
    ,
    .out_parity     (par1)
`endif
  );

  int tbl_a [16] = '{2, 13, 4, 3, 27, 3, 17, 3, 18, 12, 4, 4, 12, 7, 7, 1};
  int tbl_b [16] = '{4, 22, 19, 14, 31, 8, 26, 12, 22, 18, 7, 31, 27, 17, 8, 13};

  // Model: a stream is just "transfer number t out of total beats".
  bit act   [2];
  int t     [2];
  int total [2];

  int checks = 0;
  int errors = 0;

  function automatic int lanes_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [4*TW-1:0] exp_coef(input int lanes, input int word);
    logic [4*TW-1:0] r;
    int w;
    r = '0;
    for (int l = 0; l < lanes; l++) begin
      w = (word + l) % 16;
      r[l*TW +: TW] = TW'((tbl_b[w] << (2*CW)) | (tbl_a[w] << CW));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        if (abort) act[i] = 1'b0;
        else if (out_ready) begin
          if (t[i] == total[i] - 1) act[i] = 1'b0;
          else t[i]++;
        end
      end else if (start && rounds != 6'd0) begin
        act[i]   = 1'b1;
        t[i]     = 0;
        total[i] = int'(rounds) * (16 / lanes_of(i));
      end
    end
  endtask

  task automatic compare_all();
    int lanes, bpr, beat, rnd, wd;
    logic [4*TW-1:0] ec;
    for (int i = 0; i < 2; i++) begin
      lanes = lanes_of(i);
      bpr   = 16 / lanes;
      chk($sformatf("busy_L%0d", lanes), 64'(o_busy[i]), 64'(act[i]));
      chk($sformatf("valid_L%0d", lanes), 64'(o_valid[i]), 64'(act[i]));
      if (act[i]) begin
        beat = t[i] % bpr;
        rnd  = t[i] / bpr;
        wd   = beat * lanes;
        ec   = exp_coef(lanes, wd);
        chk($sformatf("word_L%0d", lanes), 64'(o_word[i]), 64'(wd));
        chk($sformatf("round_L%0d", lanes), 64'(o_round[i]), 64'(rnd));
        chk($sformatf("rlast_L%0d", lanes), 64'(o_rlast[i]), 64'(beat == bpr - 1));
        chk($sformatf("last_L%0d", lanes), 64'(o_last[i]), 64'(t[i] == total[i] - 1));
        chk($sformatf("coef_L%0d", lanes), 64'(o_coef[i]), 64'(ec));
`ifdef EAGLESONG_COEF_PARITY_EN
        for (int l = 0; l < lanes; l++) begin
          chk($sformatf("parity_L%0d_l%0d", lanes, l), 64'(o_par[i][l]), 64'(^ec[l*TW +: TW]));
        end
`endif
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_zero_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_valid"}, 64'(o_valid[i]), 64'd0);
      chk({tag, "_busy"},  64'(o_busy[i]),  64'd0);
      chk({tag, "_coef"},  64'(o_coef[i]),  64'd0);
      chk({tag, "_word"},  64'(o_word[i]),  64'd0);
      chk({tag, "_round"}, 64'(o_round[i]), 64'd0);
      chk({tag, "_rlast"}, 64'(o_rlast[i]), 64'd0);
      chk({tag, "_last"},  64'(o_last[i]),  64'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < 2000) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(o_busy[0] | o_busy[1]), 64'd0);
  endtask

  initial begin
    int r;
    #1;
    reset_zero_check("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single round, always ready.
    rounds = 6'd1; start = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    chk("A_l4_beat0_lane1", 64'(o_coef[0][TW +: TW]), 64'd22944);
    for (int k = 1; k < 16; k++) begin
      cycle();
      if (k == 4) begin
        chk("A_l1_beat4_coef", 64'(cf1), 64'd32608);
`ifdef EAGLESONG_COEF_PARITY_EN
        chk("A_l1_beat4_parity", 64'(par1), 64'd1);
`endif
      end
      if (k == 15) chk("A_l1_last", 64'(o_last[1]), 64'd1);
    end
    cycle();
    chk("A_l1_busy_after", 64'(o_busy[1]), 64'd0);

    // Two rounds: round boundaries on the 4-lane instance.
    rounds = 6'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      cycle();
      if (k == 3) begin
        chk("B_l4_rlast3", 64'(o_rlast[0]), 64'd1);
        chk("B_l4_round3", 64'(o_round[0]), 64'd0);
      end
      if (k == 4) chk("B_l4_round4", 64'(o_round[0]), 64'd1);
      if (k == 7) begin
        chk("B_l4_rlast7", 64'(o_rlast[0]), 64'd1);
        chk("B_l4_last7", 64'(o_last[0]), 64'd1);
      end
    end
    drain();

    // Backpressure at beat 2 for three cycles.
    rounds = 6'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    chk("C_l1_word_stall0", 64'(o_word[1]), 64'd2);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("C_l1_word_held", 64'(o_word[1]), 64'd2);
      chk("C_l1_coef_held", 64'(cf1), 64'd19584);
    end
    out_ready = 1'b1;
    cycle();
    chk("C_l1_word_next", 64'(o_word[1]), 64'd3);
    drain();

    // Ignored starts and abort.
    rounds = 6'd0; start = 1'b1;
    cycle();
    cycle();
    chk("D_zero_rounds_busy4", 64'(o_busy[0]), 64'd0);
    chk("D_zero_rounds_busy1", 64'(o_busy[1]), 64'd0);
    rounds = 6'd1;
    cycle();
    start = 1'b0;
    cycle();
    start = 1'b1; rounds = 6'd5;
    cycle();
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    chk("D_l1_word5", 64'(o_word[1]), 64'd5);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("D_l1_abort_valid", 64'(o_valid[1]), 64'd0);
    rounds = 6'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("D_l1_restart_word", 64'(o_word[1]), 64'd0);
    drain();

    // Maximum round count on the 4-lane instance.
    rounds = 6'd63; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 252; k++) begin
      cycle();
      if (k == 251) begin
        chk("E_l4_round62", 64'(o_round[0]), 64'd62);
        chk("E_l4_last", 64'(o_last[0]), 64'd1);
      end
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      start = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      if (r == 0) rounds = 6'd0;
      else if (r < 8) rounds = 6'($urandom_range(1, 3));
      else rounds = 6'($urandom_range(1, 63));
      abort = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    start = 1'b0; abort = 1'b1; out_ready = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();

    // Asynchronous reset mid-stream at beat 7.
    rounds = 6'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 8; k++) cycle();
    chk("G_l1_word7", 64'(o_word[1]), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    reset_zero_check("G_async");
    act[0] = 1'b0;
    act[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rounds = 6'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("G_l1_restart_word", 64'(o_word[1]), 64'd0);
    chk("G_l1_restart_round", 64'(o_round[1]), 64'd0);
    chk("G_l1_restart_valid", 64'(o_valid[1]), 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
